// File: rtl/counter_grid_pkg.sv
// Shared types and helpers for the counter grid bank.
package counter_grid_pkg;

  // Auto-repeat states for the step generator
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Direction of a counter step
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

  // LSB position of cell i on the packed bus; cell 0 sits in the MSBs
  function automatic int cell_lsb(input int i, input int rows, input int cols,
                                  input int width);
    return (rows * cols - 1 - i) * width;
  endfunction

endpackage

// File: rtl/counter_grid_bank_key_repeat.sv
// Button edge detection plus hold-to-repeat step generator.
// A single press steps once; holding the button steps again after
// HOLD_CYCLES and then every REPEAT_CYCLES until release.
module key_repeat
  import counter_grid_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_btn,
  input  logic dec_btn,
  input  logic clr_btn,
  output logic step_en,
  output dir_t step_dir,
  output logic clr_en
);

  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW      = $clog2(MAX_CYC);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  logic          r_inc_q, r_dec_q, r_clr_q;
  rpt_state_t    r_state, w_state_nxt;
  dir_t          r_dir, w_dir_nxt, w_step_dir;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          w_step;
  logic          w_inc_rise, w_dec_rise, w_clr_rise;
  logic          w_held, w_opp;

  assign w_inc_rise = inc_btn & ~r_inc_q;
  assign w_dec_rise = dec_btn & ~r_dec_q;
  assign w_clr_rise = clr_btn & ~r_clr_q;

  // Latched button still down, and the opposing button
  assign w_held = (r_dir == DIR_INC) ? inc_btn : dec_btn;
  assign w_opp  = (r_dir == DIR_INC) ? dec_btn : inc_btn;

  // Previous button samples; reset high so a button held through reset
  // needs a fresh press before it counts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inc_q <= 1'b1;
      r_dec_q <= 1'b1;
      r_clr_q <= 1'b1;
    end else begin
      r_inc_q <= inc_btn;
      r_dec_q <= dec_btn;
      r_clr_q <= clr_btn;
    end
  end

  // FSM state, latched direction and repeat timer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_dir   <= DIR_INC;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state, timer and step decision; clear pre-empts any step
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_timer_nxt = r_timer;
    w_step      = 1'b0;
    w_step_dir  = r_dir;
    if (w_clr_rise) begin
      w_state_nxt = IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_timer_nxt = '0;
          if (w_inc_rise && !dec_btn) begin
            w_step      = 1'b1;
            w_step_dir  = DIR_INC;
            w_dir_nxt   = DIR_INC;
            w_state_nxt = HOLD;
          end else if (w_dec_rise && !inc_btn) begin
            w_step      = 1'b1;
            w_step_dir  = DIR_DEC;
            w_dir_nxt   = DIR_DEC;
            w_state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (!w_held || w_opp) begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
          end else if (r_timer == HOLD_LAST) begin
            w_step      = 1'b1;
            w_timer_nxt = '0;
            w_state_nxt = REPEAT;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!w_held || w_opp) begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
          end else if (r_timer == REPEAT_LAST) begin
            w_step      = 1'b1;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  assign step_en  = w_step;
  assign step_dir = w_step_dir;
  assign clr_en   = w_clr_rise;

endmodule

// File: rtl/counter_grid_bank.sv
// ROWS x COLS bank of WIDTH-bit counters driven by row/column switches
// and inc/dec/clr buttons, packed for the text display's data_raw input.
module counter_grid_bank
  import counter_grid_pkg::*;
#(
  parameter int          ROWS          = 4,
  parameter int          COLS          = 4,
  parameter int          WIDTH         = 16,
  parameter int unsigned MAX_VAL       = 2**WIDTH - 1,
  parameter bit          WRAP          = 1'b0,
  parameter int          HOLD_CYCLES   = 50_000_000,
  parameter int          REPEAT_CYCLES = 10_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ROWS-1:0]             row_sel,
  input  logic [COLS-1:0]             col_sel,
  input  logic                        inc_btn,
  input  logic                        dec_btn,
  input  logic                        clr_btn,
  output logic [ROWS*COLS*WIDTH-1:0]  data_raw,
  output logic                        step
);

  localparam int NCELL = ROWS * COLS;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic w_step_en;
  dir_t w_step_dir;
  logic w_clr_en;
  logic r_step;

  // Saturating or wrapping +/-1 on one counter value
  function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] v, input dir_t d);
    if (d == DIR_INC) begin
      if (v == MAX_W) return WRAP ? '0 : MAX_W;
      else            return v + 1'b1;
    end else begin
      if (v == '0)    return WRAP ? MAX_W : '0;
      else            return v - 1'b1;
    end
  endfunction

  key_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_key_repeat (
    .clk     (clk),
    .reset   (reset),
    .inc_btn (inc_btn),
    .dec_btn (dec_btn),
    .clr_btn (clr_btn),
    .step_en (w_step_en),
    .step_dir(w_step_dir),
    .clr_en  (w_clr_en)
  );

  // One-cycle pulse after every edge that applied a step, selected or not
  always_ff @(posedge clk) begin
    if (reset) r_step <= 1'b0;
    else       r_step <= w_step_en;
  end

  assign step = r_step;

  for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell
    localparam int R   = gi / COLS;
    localparam int C   = gi % COLS;
    localparam int LSB = cell_lsb(gi, ROWS, COLS, WIDTH);

    logic [WIDTH-1:0] r_cnt;
    logic             w_sel;

    assign w_sel = row_sel[R] & col_sel[C];

    // Counter update: clear wins over step, both gated by selection
    always_ff @(posedge clk) begin
      if (reset)                  r_cnt <= '0;
      else if (w_clr_en && w_sel) r_cnt <= '0;
      else if (w_step_en && w_sel) r_cnt <= f_next(r_cnt, w_step_dir);
    end

    assign data_raw[LSB +: WIDTH] = r_cnt;
  end

endmodule
